alu_result_uart_tx: RTL and testbench

- Sends the ALU result to the host over a UART serial link.
- Data flows opposite to the operand-loading path: that path goes switches/buttons → ALU; this block goes ALU → host.
- On a send request it captures `i_resultado`, zero-extends it to 8 bits and transmits one 8N1 frame (1 start, 8 data LSB-first, 1 stop) on `o_tx`.
- Instantiated in the board top level beside the ALU. `i_send` comes from a debounced, edge-detected button pulse.

---
 rtl/alu_result_uart_tx.sv | 135 +++++++++++++
 tb/tb_alu_result_uart_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_uart_tx.sv
// -----------------------------------------------------------------------------
// alu_result_uart_tx
//
// Sends the ALU result to the host over an 8N1 UART link. A send request
// captures i_resultado, zero-extends it to NB_FRAME bits and shifts out one
// frame: start bit (0), NB_FRAME data bits LSB-first, stop bit (1).
//
// Parameters:
//   NB_DATA      width of the ALU result (1..8)
//   NB_FRAME     data bits per frame (fixed at 8)
//   CLKS_PER_BIT clk cycles per bit period (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   i_rst       asynchronous, active-high reset
//   i_resultado ALU result, sampled only when a send is accepted
//   i_send      send request, level-sampled while idle, ignored while busy
//   o_tx        serial line, idle high, registered
//   o_busy      high from the accepting edge until the frame completes
//   o_done      one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module alu_result_uart_tx #(
  parameter int NB_DATA      = 6,
  parameter int NB_FRAME     = 8,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_resultado,
  input  logic               i_send,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(NB_FRAME);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NB_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [NB_FRAME-1:0]  r_shift;

  logic                 w_bit_end;

  // Last cycle of the current bit period; the baud counter wraps here.
  assign w_bit_end = (r_baud == BAUD_LAST);

  // NOTE: every register below is assigned with <= so all of them update
  // from the same pre-edge values; blocking assignments here would let later
  // statements see half-updated state and break the FSM ordering.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;

      // o_tx is driven from the current state, so the line follows the state
      // by one cycle: it falls on the edge after the one that accepts i_send,
      // and each bit still lasts exactly CLKS_PER_BIT cycles.
      case (r_state)
        IDLE: begin
          o_tx <= 1'b1;
          if (i_send) begin
            r_shift   <= NB_FRAME'(i_resultado);
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= START;
            o_busy    <= 1'b1;
          end
        end

        START: begin
          o_tx <= 1'b0;
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        DATA: begin
          o_tx <= r_shift[r_bit_idx];
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        STOP: begin
          o_tx <= 1'b1;
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          o_tx    <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_alu_result_uart_tx
//
// Directed bench for alu_result_uart_tx with CLKS_PER_BIT=4. One instance uses
// NB_DATA=6 and is watched by a small serial receiver model; a second instance
// with NB_DATA=8 covers the full-width 0xFF frame. Inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_result_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [5:0] res;
  logic       send;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  logic [7:0] res8;
  logic       send8;
  logic       o_tx8;
  logic       o_busy8;
  logic       o_done8;

  int n_vec  = 0;
  int n_fail = 0;

  alu_result_uart_tx #(
    .NB_DATA      (6),
    .NB_FRAME     (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_resultado (res),
    .i_send      (send),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  alu_result_uart_tx #(
    .NB_DATA      (8),
    .NB_FRAME     (8),
    .CLKS_PER_BIT (CPB)
  ) dut8 (
    .clk         (clk),
    .i_rst       (rst),
    .i_resultado (res8),
    .i_send      (send8),
    .o_tx        (o_tx8),
    .o_busy      (o_busy8),
    .o_done      (o_done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Receiver model for the NB_DATA=6 instance: finds the first low cycle of a
  // start bit, then samples each bit two cycles into its period.
  // ---------------------------------------------------------------------------
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh    = '0;
  bit         rx_active = 1'b0;
  int         rx_cnt   = 0;
  int         rx_err   = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else if (!rx_active) begin
      if (o_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2 && o_tx !== 1'b0) begin
        rx_err++;
        rx_active = 1'b0;
      end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 2) % 4) == 0) begin
        rx_sh = {o_tx, rx_sh[7:1]};
      end else if (rx_cnt == 38) begin
        if (o_tx !== 1'b1) rx_err++;
        else               rx_q.push_back(rx_sh);
        rx_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (o_done === 1'b1) done_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at the falling edge where the send request was raised. Drops the
  // request after one cycle and checks every cycle of the resulting frame.
  task automatic expect_frame(input string tag, input logic [7:0] byte_exp, input bit use8);
    logic [9:0] bits;
    logic       tx_s, busy_s, done_s;
    bits = {1'b1, byte_exp, 1'b0};
    tick(1);
    send  = 1'b0;
    send8 = 1'b0;
    tx_s   = use8 ? o_tx8   : o_tx;
    busy_s = use8 ? o_busy8 : o_busy;
    check({tag, " accept tx"},   32'(tx_s),   32'(1));
    check({tag, " accept busy"}, 32'(busy_s), 32'(1));
    for (int k = 1; k <= 10 * CPB; k++) begin
      tick(1);
      tx_s   = use8 ? o_tx8   : o_tx;
      busy_s = use8 ? o_busy8 : o_busy;
      done_s = use8 ? o_done8 : o_done;
      check($sformatf("%s tx k=%0d", tag, k),   32'(tx_s),   32'(bits[(k - 1) / CPB]));
      check($sformatf("%s busy k=%0d", tag, k), 32'(busy_s), 32'(k < 10 * CPB));
      check($sformatf("%s done k=%0d", tag, k), 32'(done_s), 32'(k == 10 * CPB));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    send  = 1'b0;
    res   = '0;
    send8 = 1'b0;
    res8  = '0;

    // Reset held for three cycles, with a send pulse that must be ignored.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst tx c=%0d", c),   32'(o_tx),   32'(1));
      check($sformatf("rst busy c=%0d", c), 32'(o_busy), 32'(0));
      check($sformatf("rst done c=%0d", c), 32'(o_done), 32'(0));
      send = (c == 1);
    end
    @(negedge clk);
    send = 1'b0;
    rst  = 1'b0;
    tick(10);
    check("post-rst tx",     32'(o_tx),   32'(1));
    check("post-rst busy",   32'(o_busy), 32'(0));
    check("post-rst frames", rx_q.size(), 0);
    check("post-rst dones",  done_cnt,    0);

    // Basic frame: 6'b101101 -> 0x2D.
    res  = 6'b101101;
    send = 1'b1;
    expect_frame("basic", 8'h2D, 1'b0);
    tick(5);
    check("basic frames", rx_q.size(), 1);
    check("basic byte",   32'(rx_q[0]), 32'h2D);
    check("basic dones",  done_cnt,     1);

    // Busy lockout and value capture.
    res  = 6'h3F;
    send = 1'b1;
    tick(1);
    send = 1'b0;
    tick(11);
    check("lock busy@12", 32'(o_busy), 32'(1));
    send = 1'b1;
    res  = 6'h00;
    tick(1);
    send = 1'b0;
    tick(47);
    check("lock busy end", 32'(o_busy),   32'(0));
    check("lock tx end",   32'(o_tx),     32'(1));
    check("lock dones",    done_cnt,      2);
    check("lock frames",   rx_q.size(),   2);
    check("lock byte",     32'(rx_q[1]),  32'h3F);
    tick(20);
    check("lock no 2nd frame", rx_q.size(), 2);
    check("lock idle busy",    32'(o_busy), 32'(0));

    // Held send: back-to-back frames with one extra idle-high cycle.
    res  = 6'h01;
    send = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick(1);
      if (c >= 38 && c <= 42) check($sformatf("held stop tx c=%0d", c), 32'(o_tx), 32'(1));
      if (c == 43) check("held 2nd start tx", 32'(o_tx), 32'(0));
      if (c == 41) begin
        check("held gap done", 32'(o_done), 32'(1));
        check("held gap busy", 32'(o_busy), 32'(0));
      end
      if (c == 42) begin
        check("held 2nd busy", 32'(o_busy), 32'(1));
        check("held 2nd done", 32'(o_done), 32'(0));
      end
    end
    check("held dones@100",  done_cnt,    4);
    check("held frames@100", rx_q.size(), 4);
    send = 1'b0;
    tick(40);
    check("held dones final",  done_cnt,     5);
    check("held frames final", rx_q.size(),  5);
    check("held byte 1",       32'(rx_q[2]), 32'h01);
    check("held byte 2",       32'(rx_q[3]), 32'h01);
    check("held byte 3",       32'(rx_q[4]), 32'h01);

    // Reset mid-frame: 0x05 puts a low data bit on the line at cycle 18.
    res  = 6'h05;
    send = 1'b1;
    tick(1);
    send = 1'b0;
    tick(17);
    check("midrst tx before", 32'(o_tx), 32'(0));
    rst = 1'b1;
    #1;
    check("midrst tx async",   32'(o_tx),   32'(1));
    check("midrst busy async", 32'(o_busy), 32'(0));
    check("midrst done async", 32'(o_done), 32'(0));
    tick(2);
    rst = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      tick(1);
      check($sformatf("midrst idle tx c=%0d", c), 32'(o_tx), 32'(1));
    end
    check("midrst busy",   32'(o_busy),  32'(0));
    check("midrst dones",  done_cnt,     5);
    check("midrst frames", rx_q.size(),  5);

    // Boundary values.
    res  = 6'h00;
    send = 1'b1;
    expect_frame("zero", 8'h00, 1'b0);
    tick(5);
    check("zero frames", rx_q.size(),  6);
    check("zero byte",   32'(rx_q[5]), 32'h00);

    res8  = 8'hFF;
    send8 = 1'b1;
    expect_frame("ff8", 8'hFF, 1'b1);
    tick(5);
    check("ff8 idle busy", 32'(o_busy8), 32'(0));

    check("rx framing errors", rx_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
